// File: rtl/mem_port_arbiter.sv
// Three-way arbiter (loader, data, fetch) in front of a single-ported
// synchronous memory. One transaction in flight at a time; fixed read latency.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned LAT_W = 3;
  localparam int unsigned CNT_W = 4;
  localparam logic [LAT_W-1:0] LAT_INIT    = LAT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] STARVE_FULL = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
  typedef enum logic [1:0] {G_NONE, G_L, G_D, G_I} grant_e;

  state_e            state_q, state_d;
  grant_e            grant_q, grant_d;
  grant_e            win;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              l_ack_q, l_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              i_ack_q, i_ack_d;

  // Next-state, arbitration, starvation tracking and registered outputs.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    win         = G_NONE;
    lat_d       = lat_q;
    starve_d    = i_req ? starve_q : '0;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    l_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_ack_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // L always first; a starved fetch overtakes D but never L.
        if (l_req)                                        win = G_L;
        else if (d_req && !(i_req && starve_q == STARVE_FULL)) win = G_D;
        else if (i_req)                                   win = G_I;

        if (i_req) begin
          if (win == G_I)                                   starve_d = '0;
          else if (win == G_D && starve_q != STARVE_FULL)   starve_d = starve_q + CNT_W'(1);
        end

        if (win != G_NONE) begin
          grant_d  = win;
          mem_en_d = 1'b1;
          state_d  = S_ISSUE;
          unique case (win)
            G_L: begin
              mem_we_d    = l_we;
              mem_addr_d  = l_addr;
              mem_wdata_d = l_wdata;
            end
            G_D: begin
              mem_we_d    = d_we;
              mem_addr_d  = d_addr;
              mem_wdata_d = d_wdata;
            end
            default: begin
              mem_we_d    = 1'b0;
              mem_addr_d  = i_addr;
              mem_wdata_d = '0;
            end
          endcase
        end
      end
      S_ISSUE: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        if (mem_we_q) begin
          state_d = S_RESP;
        end else begin
          lat_d   = LAT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q == LAT_W'(1)) begin
          rdata_d = mem_rdata;
          state_d = S_RESP;
        end
      end
      default: begin
        unique case (grant_q)
          G_L:     l_ack_d = 1'b1;
          G_D:     d_ack_d = 1'b1;
          G_I:     i_ack_d = 1'b1;
          default: ;
        endcase
        grant_d = G_NONE;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      grant_q     <= G_NONE;
      lat_q       <= '0;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      l_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_ack_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      l_ack_q     <= l_ack_d;
      d_ack_q     <= d_ack_d;
      i_ack_q     <= i_ack_d;
    end
  end

  assign l_ack     = l_ack_q;
  assign d_ack     = d_ack_q;
  assign i_ack     = i_ack_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
